// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 bit multiplexer.
// Optional per-owner hold timeout is compiled in with MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       active
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("HOLD_MAX must be in 1..255");
  end

  state_t     r_state, w_state_n;
  logic [2:0] r_sel,   w_sel_n;
  logic [7:0] r_gnt,   w_gnt_n;
  logic       r_active, w_active_n;
  logic [2:0] r_ptr,   w_ptr_n;
  logic       w_found;
  logic [2:0] w_win;
  logic       w_load;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);
  logic [7:0] r_hcnt, w_hcnt_n;
`endif

  // First set bit scanning ptr, ptr+1, ... with 3-bit wrap.
  function automatic logic [3:0] rr_pick(input logic [7:0] v, input logic [2:0] p);
    logic       found;
    logic [2:0] idx;
    logic [2:0] win;
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && v[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  always_comb begin
    w_state_n  = r_state;
    w_sel_n    = r_sel;
    w_gnt_n    = r_gnt;
    w_active_n = r_active;
    w_ptr_n    = r_ptr;
    w_load     = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
    w_hcnt_n   = r_hcnt;
`endif
    {w_found, w_win} = rr_pick(req, r_ptr);

    case (r_state)
      S_IDLE: begin
        if (w_found) w_load = 1'b1;
      end
      S_GRANT: begin
        if (!req[r_sel]) begin
          if (w_found) begin
            w_load = 1'b1;
          end else begin
            w_state_n  = S_IDLE;
            w_gnt_n    = '0;
            w_active_n = 1'b0;
          end
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
          // ptr already sits past the owner, so the owner scans last.
          if (r_hcnt == HOLD_LIM && (req & ~r_gnt) != '0) begin
            w_load = 1'b1;
          end else if (r_hcnt != HOLD_LIM) begin
            w_hcnt_n = r_hcnt + 8'd1;
          end
`endif
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_load) begin
      w_state_n  = S_GRANT;
      w_sel_n    = w_win;
      w_gnt_n    = 8'd1 << w_win;
      w_active_n = 1'b1;
      w_ptr_n    = w_win + 3'd1;
`ifdef MUX_ARB_TIMEOUT_EN
      w_hcnt_n   = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_gnt    <= '0;
      r_active <= 1'b0;
      r_ptr    <= '0;
`ifdef MUX_ARB_TIMEOUT_EN
      r_hcnt   <= '0;
`endif
    end else begin
      r_state  <= w_state_n;
      r_sel    <= w_sel_n;
      r_gnt    <= w_gnt_n;
      r_active <= w_active_n;
      r_ptr    <= w_ptr_n;
`ifdef MUX_ARB_TIMEOUT_EN
      r_hcnt   <= w_hcnt_n;
`endif
    end
  end

  assign sel    = r_sel;
  assign gnt    = r_gnt;
  assign active = r_active;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter; expectations queued at drive time.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       active;

  typedef struct {
    string      tag;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       act;
  } exp_t;

  exp_t q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mux_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .sel    (sel),
    .gnt    (gnt),
    .active (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive at the falling edge; the expectation applies after the next rising edge.
  task automatic drive(input logic [7:0] r, input logic rs, input logic [7:0] eg,
                       input logic [2:0] es, input logic ea, input string tag);
    exp_t e;
    @(negedge clk);
    req = r;
    rst = rs;
    e.tag = tag; e.gnt = eg; e.sel = es; e.act = ea;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(e.tag, {20'd0, e.act, e.sel, e.gnt}, {20'd0, active, sel, gnt});
        chk({e.tag, "_onehot"}, {31'd0, $countones(gnt) <= 1}, 32'd1);
      end
    end
  end

  initial begin
    logic [7:0] eg;
    int unsigned o;
    req = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    drive(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "reset");
    for (int i = 0; i < 5; i++) drive(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "idle");

    drive(8'h24, 1'b0, 8'h04, 3'd2, 1'b1, "first_grant");
    drive(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, "handoff");
    drive(8'h00, 1'b0, 8'h00, 3'd5, 1'b0, "release_idle");

    drive(8'h80, 1'b0, 8'h80, 3'd7, 1'b1, "grant7");
    drive(8'h00, 1'b0, 8'h00, 3'd7, 1'b0, "release7");
    drive(8'h81, 1'b0, 8'h01, 3'd0, 1'b1, "ptr_wrap");
    drive(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, "release0");

    drive(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "reset2");
`ifdef MUX_ARB_TIMEOUT_EN
    for (int k = 0; k < 24; k++) begin
      o  = (k / 4) % 2;
      eg = 8'(1 << o);
      drive(8'h03, 1'b0, eg, 3'(o), 1'b1, "timeout_rot");
    end
`else
    for (int k = 0; k < 50; k++) drive(8'h03, 1'b0, 8'h01, 3'd0, 1'b1, "no_timeout");
`endif
    for (int k = 0; k < 20; k++) drive(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, "sole_owner");

    drive(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "reset3");
    drive(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, "grant3");
    drive(8'h0A, 1'b0, 8'h08, 3'd3, 1'b1, "glitch_hold");
    drive(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, "glitch_after");
    drive(8'h08, 1'b1, 8'h00, 3'd0, 1'b0, "rst_midgrant");
    drive(8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, "post_rst_ff");
    drive(8'hFE, 1'b0, 8'h02, 3'd1, 1'b1, "ff_next");
    drive(8'h00, 1'b0, 8'h00, 3'd1, 1'b0, "final_idle");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
